// File: rtl/pc_unit.sv
// pc_unit: program-counter unit for the single-cycle core.
// Holds the architectural PC and selects the next PC from sequential,
// conditional-branch, JAL and JALR sources, with stall, program-limit halt,
// resume, and optional misaligned-target trapping.
// Optional feature macro: PC_MISALIGN_TRAP_EN (enables the TRAP state; when
// undefined, misaligned targets are loaded with bits [1:0] cleared).
module pc_unit #(
    parameter int unsigned      XLEN     = 32,
    parameter int unsigned      IMM_W    = 64,
    parameter logic [XLEN-1:0]  RESET_PC = '0,
    parameter logic [XLEN-1:0]  PC_LIMIT = 'h200
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             branch,
    input  logic             alu_zero,
    input  logic             branch_inv,
    input  logic             jal,
    input  logic             jalr,
    input  logic [IMM_W-1:0] imm,
    input  logic [XLEN-1:0]  rs1_val,
    input  logic             resume,
    output logic [XLEN-1:0]  pc_out,
    output logic [XLEN-1:0]  pc_plus4,
    output logic             redirect,
    output logic             halted,
    output logic             trap,
    output logic [XLEN-1:0]  trap_pc
);

`ifdef PC_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_HALT = 2'd1,
        S_TRAP = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_HALT = 2'd1
    } state_t;
`endif

    state_t            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic              redirect_q, redirect_d;
`ifdef PC_MISALIGN_TRAP_EN
    logic [XLEN-1:0]   trap_pc_q, trap_pc_d;
`endif

    logic [XLEN-1:0]   imm_x;
    logic [XLEN-1:0]   tgt_seq;
    logic [XLEN-1:0]   tgt_rel;
    logic [XLEN-1:0]   tgt_jalr;
    logic [XLEN-1:0]   nxt;
    logic              nxt_redir;
    logic              nxt_is_jalr;
    logic              misalign;
`ifndef PC_MISALIGN_TRAP_EN
    logic [XLEN-1:0]   nxt_masked;
`endif

    // Candidate targets; the size cast sign-extends or truncates imm to XLEN
    always_comb begin
        imm_x    = XLEN'($signed(imm));
        tgt_seq  = pc_q + XLEN'(4);
        tgt_rel  = pc_q + {imm_x[XLEN-2:0], 1'b0};
        tgt_jalr = (rs1_val + imm_x) & ~XLEN'(1);
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_RUN;
            pc_q       <= RESET_PC;
            redirect_q <= 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
            trap_pc_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            redirect_q <= redirect_d;
`ifdef PC_MISALIGN_TRAP_EN
            trap_pc_q  <= trap_pc_d;
`endif
        end
    end

    // Next-state / next-PC selection and limit/alignment checks
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        redirect_d  = redirect_q;
`ifdef PC_MISALIGN_TRAP_EN
        trap_pc_d   = trap_pc_q;
`else
        nxt_masked  = '0;
`endif
        nxt         = tgt_seq;
        nxt_redir   = 1'b0;
        nxt_is_jalr = 1'b0;
        misalign    = 1'b0;

        case (state_q)
            S_RUN: begin
                if (stall) begin
                    // Held PC; any redirect request this cycle is dropped
                    redirect_d = 1'b0;
                end else begin
                    if (jalr) begin
                        nxt         = tgt_jalr;
                        nxt_redir   = 1'b1;
                        nxt_is_jalr = 1'b1;
                    end else if (jal) begin
                        nxt       = tgt_rel;
                        nxt_redir = 1'b1;
                    end else if (branch && (alu_zero ^ branch_inv)) begin
                        nxt       = tgt_rel;
                        nxt_redir = 1'b1;
                    end else begin
                        nxt = tgt_seq;
                    end

                    misalign = nxt_is_jalr ? nxt[1] : (|nxt[1:0]);

`ifdef PC_MISALIGN_TRAP_EN
                    if (nxt >= PC_LIMIT) begin
                        state_d = S_HALT;
                    end else if (misalign) begin
                        state_d   = S_TRAP;
                        trap_pc_d = nxt;
                    end else begin
                        pc_d       = nxt;
                        redirect_d = nxt_redir;
                    end
`else
                    nxt_masked = misalign ? {nxt[XLEN-1:2], 2'b00} : nxt;
                    if (nxt_masked >= PC_LIMIT) begin
                        state_d = S_HALT;
                    end else begin
                        pc_d       = nxt_masked;
                        redirect_d = nxt_redir;
                    end
`endif
                end
            end

`ifdef PC_MISALIGN_TRAP_EN
            S_HALT, S_TRAP: begin
                if (resume) begin
                    state_d    = S_RUN;
                    pc_d       = RESET_PC;
                    redirect_d = 1'b0;
                    trap_pc_d  = '0;
                end
            end
`else
            S_HALT: begin
                if (resume) begin
                    state_d    = S_RUN;
                    pc_d       = RESET_PC;
                    redirect_d = 1'b0;
                end
            end
`endif

            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    // Outputs: status flags decode the registered state; pc_plus4 is the link value
    always_comb begin
        pc_out   = pc_q;
        pc_plus4 = pc_q + XLEN'(4);
        redirect = redirect_q;
        halted   = (state_q == S_HALT);
`ifdef PC_MISALIGN_TRAP_EN
        trap     = (state_q == S_TRAP);
        trap_pc  = trap_pc_q;
`else
        trap     = 1'b0;
        trap_pc  = '0;
`endif
    end

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed self-checking bench for pc_unit (default build,
// PC_MISALIGN_TRAP_EN undefined, default parameters).
module tb_pc_unit;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        branch;
    logic        alu_zero;
    logic        branch_inv;
    logic        jal;
    logic        jalr;
    logic [63:0] imm;
    logic [31:0] rs1_val;
    logic        resume;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        redirect;
    logic        halted;
    logic        trap;
    logic [31:0] trap_pc;

    int checks = 0;
    int errors = 0;

    pc_unit #(
        .XLEN     (32),
        .IMM_W    (64),
        .RESET_PC (32'h0),
        .PC_LIMIT (32'h200)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .branch     (branch),
        .alu_zero   (alu_zero),
        .branch_inv (branch_inv),
        .jal        (jal),
        .jalr       (jalr),
        .imm        (imm),
        .rs1_val    (rs1_val),
        .resume     (resume),
        .pc_out     (pc_out),
        .pc_plus4   (pc_plus4),
        .redirect   (redirect),
        .halted     (halted),
        .trap       (trap),
        .trap_pc    (trap_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic [31:0] exp_pc,
                               input logic exp_redir, input logic exp_halt);
        check({tag, " pc_out"},   pc_out,          exp_pc);
        check({tag, " redirect"}, {31'd0, redirect}, {31'd0, exp_redir});
        check({tag, " halted"},   {31'd0, halted},   {31'd0, exp_halt});
    endtask

    // one clock edge, then return at the following falling edge for sampling
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        stall      = 1'b0;
        branch     = 1'b0;
        alu_zero   = 1'b0;
        branch_inv = 1'b0;
        jal        = 1'b0;
        jalr       = 1'b0;
        imm        = '0;
        rs1_val    = '0;
        resume     = 1'b0;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // reset values
        check_state("reset", 32'h0, 1'b0, 1'b0);
        check("reset trap",    {31'd0, trap}, 32'h0);
        check("reset trap_pc", trap_pc,       32'h0);
        check("reset pc_plus4", pc_plus4,     32'h4);

        reset = 1'b1;
        step(); check_state("seq1", 32'h4, 1'b0, 1'b0);
        step(); check_state("seq2", 32'h8, 1'b0, 1'b0);
        check("seq2 pc_plus4", pc_plus4, 32'hC);
        step(); check("seq3 pc_out", pc_out, 32'hC);
        step(); check("seq4 pc_out", pc_out, 32'h10);

        // taken branch: 0x10 + (8<<1)
        branch = 1'b1; alu_zero = 1'b1; imm = 64'd8;
        step(); check_state("br_taken", 32'h20, 1'b1, 1'b0);
        idle_inputs();
        step(); check_state("after_br", 32'h24, 1'b0, 1'b0);

        // jal back: 0x24 + (-10<<1) = 0x10
        jal = 1'b1; imm = 64'hFFFF_FFFF_FFFF_FFF6;
        step(); check_state("jal_neg", 32'h10, 1'b1, 1'b0);
        idle_inputs();

        // branch_inv with zero=1 is not taken
        branch = 1'b1; alu_zero = 1'b1; branch_inv = 1'b1; imm = 64'd8;
        step(); check_state("br_inv_nt", 32'h14, 1'b0, 1'b0);

        // zero=0, inv=0: not taken
        branch = 1'b1; alu_zero = 1'b0; branch_inv = 1'b0; imm = 64'd8;
        step(); check_state("br_nt", 32'h18, 1'b0, 1'b0);

        // zero=0, inv=1: taken, 0x18 + 8
        branch = 1'b1; alu_zero = 1'b0; branch_inv = 1'b1; imm = 64'd4;
        step(); check_state("br_inv_t", 32'h20, 1'b1, 1'b0);
        idle_inputs();

        // stall drops the jal
        stall = 1'b1; jal = 1'b1; imm = 64'hFFFF_FFFF_FFFF_FFFC;
        step(); check_state("stall", 32'h20, 1'b0, 1'b0);
        stall = 1'b0;
        step(); check_state("unstall_jal", 32'h18, 1'b1, 1'b0);
        idle_inputs();

        // jalr beats jal: (0x41+3)&~1
        jal = 1'b1; jalr = 1'b1; rs1_val = 32'h41; imm = 64'd3;
        step(); check_state("jalr_wins", 32'h44, 1'b1, 1'b0);
        idle_inputs();

        // upper imm bits truncated: immX = 4, 0x44 + 8
        jal = 1'b1; imm = 64'h0000_0001_0000_0004;
        step(); check_state("imm_trunc", 32'h4C, 1'b1, 1'b0);
        idle_inputs();

        jalr = 1'b1; rs1_val = 32'h8; imm = 64'd0;
        step(); check_state("jalr_to8", 32'h8, 1'b1, 1'b0);
        idle_inputs();

        // misaligned jal target 0xA is masked to 0x8
        jal = 1'b1; imm = 64'd1;
        step(); check_state("misalign_jal", 32'h8, 1'b1, 1'b0);
        check("misalign trap", {31'd0, trap}, 32'h0);
        check("misalign trap_pc", trap_pc, 32'h0);
        idle_inputs();

        // misaligned jalr: 0x13 -> 0x12 -> masked 0x10
        jalr = 1'b1; rs1_val = 32'h13;
        step(); check_state("misalign_jalr", 32'h10, 1'b1, 1'b0);
        idle_inputs();

        // run to the limit
        jalr = 1'b1; rs1_val = 32'h1F0;
        step(); check_state("to_1f0", 32'h1F0, 1'b1, 1'b0);
        idle_inputs();
        step(); step(); step();
        check_state("at_1fc", 32'h1FC, 1'b0, 1'b0);
        step(); check_state("halt_entry", 32'h1FC, 1'b0, 1'b1);

        // inputs other than resume are ignored while halted
        for (int i = 0; i < 10; i++) begin
            stall  = i[0];
            jal    = 1'b1;
            jalr   = i[1];
            branch = 1'b1; alu_zero = 1'b1;
            imm    = 64'd2;
            rs1_val = 32'h40;
            step();
        end
        check_state("halt_hold", 32'h1FC, 1'b0, 1'b1);
        idle_inputs();

        resume = 1'b1;
        step(); check_state("resume", 32'h0, 1'b0, 1'b0);
        resume = 1'b0;
        step(); check_state("post_resume", 32'h4, 1'b0, 1'b0);

        // resume in RUN is ignored
        resume = 1'b1;
        step(); check_state("resume_run", 32'h8, 1'b0, 1'b0);
        idle_inputs();

        // jump past the limit halts with pc held
        jalr = 1'b1; rs1_val = 32'h300;
        step(); check_state("jump_over", 32'h8, 1'b0, 1'b1);
        idle_inputs();
        resume = 1'b1;
        step(); check_state("resume2", 32'h0, 1'b0, 1'b0);
        idle_inputs();

        // wrap-around: 0 + (-2<<1) = 0xFFFFFFFC is above the limit
        jal = 1'b1; imm = 64'hFFFF_FFFF_FFFF_FFFE;
        step(); check_state("wrap_halt", 32'h0, 1'b0, 1'b1);
        idle_inputs();
        resume = 1'b1;
        step(); resume = 1'b0;
        step(); step();
        check("pre_async pc_out", pc_out, 32'h8);

        // asynchronous reset between edges
        #2 reset = 1'b0;
        #1 check_state("async_reset", 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        step(); check_state("after_async", 32'h4, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
